// File: rtl/frame_pkg.sv
// Definitions shared by the line mapper and demapper: framing constants,
// the alignment state encoding and the CRC-8 byte update.
package frame_pkg;

  localparam int unsigned DEF_ROWS  = 4;
  localparam int unsigned DEF_COLS  = 1024;
  localparam logic [7:0]  FAS_BYTE  = 8'hF6;
  localparam logic [7:0]  CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    HUNT,
    PRESYNC,
    SYNC
  } align_state_e;

  // MSB-first CRC-8 update of one byte, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic [7:0] d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[7] ^ d[7]) c = (c << 1) ^ CRC8_POLY;
      else             c = c << 1;
      d = d << 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/demap_align.sv
// Frame alignment for the demapper: HUNT/PRESYNC/SYNC state machine, row and
// column position of the next line byte, and the consecutive bad-FAS counter.
module demap_align
  import frame_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned LOF_THRESH = 3,
  parameter logic [7:0]  FAS_BYTE   = frame_pkg::FAS_BYTE,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  input  logic          i_fas,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_in_sync,
  output logic          o_frame_start
);

  localparam int unsigned BW = $clog2(LOF_THRESH + 1);

  align_state_e  r_state, w_state;
  logic [RW-1:0] r_row, w_row;
  logic [CW-1:0] r_col, w_col;
  logic [BW-1:0] r_bad, w_bad;

  logic          w_at_start;
  logic          w_fas_ok;
  logic [RW-1:0] w_row_adv;
  logic [CW-1:0] w_col_adv;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= HUNT;
      r_row   <= '0;
      r_col   <= '0;
      r_bad   <= '0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= w_col;
      r_bad   <= w_bad;
    end
  end

  always_comb begin
    w_col_adv = r_col + CW'(1);
    w_row_adv = r_row;
    if (r_col == CW'(COLS - 1)) begin
      w_col_adv = '0;
      w_row_adv = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
    end
  end

  // Counters hold the position of the next byte; a FAS hit in HUNT is row 0,
  // column 0, so the byte after it is column 1.
  always_comb begin
    w_state       = r_state;
    w_row         = r_row;
    w_col         = r_col;
    w_bad         = r_bad;
    w_at_start    = (r_row == '0) && (r_col == '0);
    w_fas_ok      = i_fas && (i_data == FAS_BYTE);
    o_frame_start = i_valid && (r_state != HUNT) && w_at_start;
    if (i_valid) begin
      case (r_state)
        HUNT: begin
          if (w_fas_ok) begin
            w_state = PRESYNC;
            w_row   = '0;
            w_col   = CW'(1);
          end
        end
        PRESYNC: begin
          w_row = w_row_adv;
          w_col = w_col_adv;
          if (w_at_start) begin
            if (w_fas_ok) begin
              w_state = SYNC;
              w_bad   = '0;
            end else begin
              w_state = HUNT;
              w_row   = '0;
              w_col   = '0;
            end
          end
        end
        SYNC: begin
          w_row = w_row_adv;
          w_col = w_col_adv;
          if (w_at_start) begin
            if (w_fas_ok) begin
              w_bad = '0;
            end else if (r_bad == BW'(LOF_THRESH - 1)) begin
              w_state = HUNT;
              w_bad   = '0;
              w_row   = '0;
              w_col   = '0;
            end else begin
              w_bad = r_bad + BW'(1);
            end
          end
        end
        default: begin
          w_state = HUNT;
          w_row   = '0;
          w_col   = '0;
          w_bad   = '0;
        end
      endcase
    end
  end

  assign o_row     = r_row;
  assign o_col     = r_col;
  assign o_in_sync = (r_state == SYNC);

endmodule

// File: rtl/demapper.sv
// Receive-side frame demapper: aligns on FAS, strips overhead, forwards
// payload to the client FIFO and checks the per-frame CRC-8.
// Optional error counters are built when DEMAP_ERR_CNT_EN is defined.
module demapper
  import frame_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned LOF_THRESH = 3,
  parameter logic [7:0]  FAS_BYTE   = frame_pkg::FAS_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_frame_data,
  input  logic        i_frame_data_valid,
  input  logic        i_frame_data_fas,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  input  logic        i_client_fifo_ready,
  output logic        o_frame_done,
  output logic        o_crc_err,
  output logic [7:0]  o_crc_val,
  output logic        o_line_retrans_req,
  output logic        o_in_sync,
  output logic        o_pyld_ovf
`ifdef DEMAP_ERR_CNT_EN
  ,
  output logic [15:0] o_crc_err_cnt,
  output logic [15:0] o_lof_cnt
`endif
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_in_sync;
  logic          w_frame_start;
  logic          w_accept;
  logic          w_is_crc;
  logic          w_is_pyld;
  logic          w_crc_mismatch;

  logic [7:0]    r_crc;
  logic          r_pyld_valid;

  demap_align #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LOF_THRESH (LOF_THRESH),
    .FAS_BYTE   (FAS_BYTE)
  ) u_align (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_frame_data),
    .i_valid       (i_frame_data_valid),
    .i_fas         (i_frame_data_fas),
    .o_row         (w_row),
    .o_col         (w_col),
    .o_in_sync     (w_in_sync),
    .o_frame_start (w_frame_start)
  );

  assign w_accept       = i_frame_data_valid && w_in_sync;
  assign w_is_crc       = (w_row == RW'(ROWS - 1)) && (w_col == CW'(COLS - 1));
  assign w_is_pyld      = (w_col != '0) && !w_is_crc;
  assign w_crc_mismatch = (i_frame_data != r_crc);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_crc              <= '0;
      r_pyld_valid       <= 1'b0;
      o_pyld_data        <= '0;
      o_pyld_ovf         <= 1'b0;
      o_frame_done       <= 1'b0;
      o_crc_err          <= 1'b0;
      o_crc_val          <= '0;
      o_line_retrans_req <= 1'b0;
    end else begin
      r_pyld_valid       <= w_accept && w_is_pyld;
      o_frame_done       <= 1'b0;
      o_crc_err          <= 1'b0;
      o_line_retrans_req <= 1'b0;
      if (w_accept && w_is_pyld) o_pyld_data <= i_frame_data;
      // A byte offered while the FIFO is full is lost but was already in the CRC.
      if (r_pyld_valid && !i_client_fifo_ready) o_pyld_ovf <= 1'b1;
      if (!w_in_sync || w_frame_start) begin
        r_crc <= '0;
      end else if (w_accept) begin
        if (w_is_crc) begin
          o_frame_done       <= 1'b1;
          o_crc_err          <= w_crc_mismatch;
          o_line_retrans_req <= w_crc_mismatch;
          o_crc_val          <= r_crc;
          r_crc              <= '0;
        end else if (w_is_pyld) begin
          r_crc <= crc8_byte(r_crc, i_frame_data);
        end
      end
    end
  end

  assign o_pyld_data_valid = r_pyld_valid && i_client_fifo_ready;
  assign o_in_sync         = w_in_sync;

`ifdef DEMAP_ERR_CNT_EN
  logic r_sync_d;

  // SYNC only ever exits to HUNT, so a falling in_sync marks loss of frame.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync_d      <= 1'b0;
      o_crc_err_cnt <= '0;
      o_lof_cnt     <= '0;
    end else begin
      r_sync_d <= w_in_sync;
      if (o_crc_err && (o_crc_err_cnt != '1)) o_crc_err_cnt <= o_crc_err_cnt + 16'd1;
      if (r_sync_d && !w_in_sync && (o_lof_cnt != '1)) o_lof_cnt <= o_lof_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demapper.sv
// Directed, table-driven bench for demapper with a 4x8 frame (27 payload bytes).
module tb_demapper;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int FLEN = ROWS * COLS;
  localparam int NPAY = ROWS * (COLS - 1) - 1;

  typedef logic [7:0] pay_t [NPAY];

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_frame_data = '0;
  logic        i_frame_data_valid = 1'b0;
  logic        i_frame_data_fas = 1'b0;
  logic        i_client_fifo_ready = 1'b1;
  logic [7:0]  o_pyld_data;
  logic        o_pyld_data_valid;
  logic        o_frame_done;
  logic        o_crc_err;
  logic [7:0]  o_crc_val;
  logic        o_line_retrans_req;
  logic        o_in_sync;
  logic        o_pyld_ovf;
`ifdef DEMAP_ERR_CNT_EN
  logic [15:0] o_crc_err_cnt;
  logic [15:0] o_lof_cnt;
`endif

  always #5 clk = ~clk;

  demapper #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LOF_THRESH (3),
    .FAS_BYTE   (8'hF6)
  ) dut (
    .i_clk               (clk),
    .i_rst               (i_rst),
    .i_frame_data        (i_frame_data),
    .i_frame_data_valid  (i_frame_data_valid),
    .i_frame_data_fas    (i_frame_data_fas),
    .o_pyld_data         (o_pyld_data),
    .o_pyld_data_valid   (o_pyld_data_valid),
    .i_client_fifo_ready (i_client_fifo_ready),
    .o_frame_done        (o_frame_done),
    .o_crc_err           (o_crc_err),
    .o_crc_val           (o_crc_val),
    .o_line_retrans_req  (o_line_retrans_req),
    .o_in_sync           (o_in_sync),
    .o_pyld_ovf          (o_pyld_ovf)
`ifdef DEMAP_ERR_CNT_EN
    ,
    .o_crc_err_cnt       (o_crc_err_cnt),
    .o_lof_cnt           (o_lof_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input pay_t m);
    logic [8:0] rem;
    rem = '0;
    for (int i = 0; i < NPAY + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        logic [7:0] cur;
        cur = (i < NPAY) ? m[i] : 8'h00;
        rem = {rem[7:0], cur[b]};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  logic [7:0] rx_q[$];
  logic       done_err_q[$];
  logic [7:0] done_val_q[$];
  int         retrans_n = 0;
  int         pulse_bad = 0;

  always @(negedge clk) begin
    if (o_pyld_data_valid === 1'b1) rx_q.push_back(o_pyld_data);
    if (o_frame_done === 1'b1) begin
      done_err_q.push_back(o_crc_err);
      done_val_q.push_back(o_crc_val);
    end
    if (o_line_retrans_req === 1'b1) begin
      retrans_n++;
      if (!(o_frame_done === 1'b1 && o_crc_err === 1'b1)) pulse_bad++;
    end
    if (o_crc_err === 1'b1 && o_frame_done !== 1'b1) pulse_bad++;
  end

  logic       drop_pend = 1'b0;
  logic       want_sync = 1'b0;
  logic       sync_early;
  logic [7:0] frm [FLEN];
  logic       frm_fas [FLEN];
  pay_t       pay_sent;
  pay_t       pay_rx;

  task automatic drive_cycle(input logic [7:0] d, input logic v, input logic f, input logic rst);
    @(posedge clk);
    #1;
    i_rst               = rst;
    i_frame_data        = d;
    i_frame_data_valid  = v;
    i_frame_data_fas    = f;
    i_client_fifo_ready = !drop_pend;
    drop_pend           = 1'b0;
    @(negedge clk);
    if (want_sync) begin
      sync_early = o_in_sync;
      want_sync  = 1'b0;
    end
  endtask

  task automatic build_frame(input logic [7:0] fas, input logic [7:0] base, input int flip);
    int k;
    k = 0;
    for (int i = 0; i < NPAY; i++) begin
      pay_sent[i] = base + 8'(i);
      pay_rx[i]   = pay_sent[i] ^ ((i == flip) ? 8'h01 : 8'h00);
    end
    for (int p = 0; p < FLEN; p++) begin
      frm_fas[p] = 1'b0;
      if (p == 0) begin
        frm[p]     = fas;
        frm_fas[p] = 1'b1;
      end else if (p % COLS == 0) begin
        frm[p] = 8'h5A;
      end else if (p == FLEN - 1) begin
        frm[p] = ref_crc(pay_sent);
      end else begin
        frm[p] = pay_rx[k];
        k++;
      end
    end
  endtask

  task automatic send_frame(input int drop, input bit gaps);
    int k;
    k = 0;
    for (int p = 0; p < FLEN; p++) begin
      if (gaps) repeat ($urandom_range(0, 1)) drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
      drive_cycle(frm[p], 1'b1, frm_fas[p], 1'b1);
      if (p == 0) want_sync = 1'b1;
      if (p % COLS != 0 && p != FLEN - 1) begin
        if (k == drop) drop_pend = 1'b1;
        k++;
      end
    end
  endtask

  typedef struct {
    logic [7:0] fas;
    int         flip;
    int         drop;
    bit         gaps;
    bit         exp_sync_early;
    bit         exp_sync;
    int         exp_npyld;
    int         exp_done;
    bit         exp_err;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{8'hF6, -1, -1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 1'b0};
    tbl[1]  = '{8'hF6, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b0};
    tbl[2]  = '{8'hF6,  5, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b1, 1'b0};
    tbl[3]  = '{8'hF6, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b0};
    tbl[4]  = '{8'hF6, -1, 10, 1'b0, 1'b1, 1'b1, 26, 1, 1'b0, 1'b1};
    tbl[5]  = '{8'hF6, -1, -1, 1'b1, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[6]  = '{8'h00, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[7]  = '{8'h00, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[8]  = '{8'hF6, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[9]  = '{8'h00, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[10] = '{8'h00, -1, -1, 1'b0, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};
    tbl[11] = '{8'h00, -1, -1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 1'b1};
    tbl[12] = '{8'hF6, -1, -1, 1'b0, 1'b0, 1'b0,  0, 0, 1'b0, 1'b1};
    tbl[13] = '{8'hF6, -1, -1, 1'b1, 1'b1, 1'b1, 27, 1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {11'd0, o_pyld_data, o_pyld_data_valid, o_frame_done, o_crc_err, o_crc_val,
           o_line_retrans_req, o_in_sync, o_pyld_ovf}, 32'd0);
    drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      int bad;
      rx_q.delete();
      done_err_q.delete();
      done_val_q.delete();
      retrans_n  = 0;
      sync_early = 1'bx;
      build_frame(tbl[i].fas, 8'(i * 17), tbl[i].flip);
      send_frame(tbl[i].drop, tbl[i].gaps);
      repeat (2) drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);

      check($sformatf("v%0d_sync_after_fas", i), 32'(sync_early), 32'(tbl[i].exp_sync_early));
      check($sformatf("v%0d_in_sync", i), 32'(o_in_sync), 32'(tbl[i].exp_sync));
      check($sformatf("v%0d_pyld_count", i), 32'(rx_q.size()), 32'(tbl[i].exp_npyld));
      if (rx_q.size() == tbl[i].exp_npyld && tbl[i].exp_npyld > 0) begin
        int k;
        bad = 0;
        k = 0;
        for (int j = 0; j < NPAY; j++) begin
          if (j != tbl[i].drop) begin
            if (rx_q[k] !== pay_rx[j]) bad++;
            k++;
          end
        end
        check($sformatf("v%0d_pyld_bytes_wrong", i), 32'(bad), 32'd0);
      end
      check($sformatf("v%0d_frame_done", i), 32'(done_err_q.size()), 32'(tbl[i].exp_done));
      if (done_err_q.size() == 1 && tbl[i].exp_done == 1) begin
        check($sformatf("v%0d_crc_err", i), 32'(done_err_q[0]), 32'(tbl[i].exp_err));
        check($sformatf("v%0d_crc_val", i), 32'(done_val_q[0]), 32'(ref_crc(pay_rx)));
      end
      check($sformatf("v%0d_retrans_pulses", i), 32'(retrans_n), 32'(tbl[i].exp_err));
      check($sformatf("v%0d_pyld_ovf", i), 32'(o_pyld_ovf), 32'(tbl[i].exp_ovf));
    end

    check("retrans_outside_err_frame", 32'(pulse_bad), 32'd0);
`ifdef DEMAP_ERR_CNT_EN
    check("crc_err_cnt", 32'(o_crc_err_cnt), 32'd1);
    check("lof_cnt", 32'(o_lof_cnt), 32'd1);
`endif

    // Reset in the middle of a frame while in SYNC
    build_frame(8'hF6, 8'h40, -1);
    for (int p = 0; p < 16; p++) drive_cycle(frm[p], 1'b1, frm_fas[p], 1'b1);
    drive_cycle(frm[16], 1'b1, frm_fas[16], 1'b0);
    drive_cycle(frm[17], 1'b1, frm_fas[17], 1'b1);
    check("midreset_outputs",
          {11'd0, o_pyld_data, o_pyld_data_valid, o_frame_done, o_crc_err, o_crc_val,
           o_line_retrans_req, o_in_sync, o_pyld_ovf}, 32'd0);
`ifdef DEMAP_ERR_CNT_EN
    check("midreset_counters", {o_crc_err_cnt, o_lof_cnt}, 32'd0);
`endif
    rx_q.delete();
    done_err_q.delete();
    for (int p = 18; p < FLEN; p++) drive_cycle(frm[p], 1'b1, frm_fas[p], 1'b1);
    repeat (2) drive_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    check("midreset_rest_pyld", 32'(rx_q.size()), 32'd0);
    check("midreset_rest_done", 32'(done_err_q.size()), 32'd0);
    check("midreset_in_sync", 32'(o_in_sync), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
